// File: rtl/instr_encoder_if.sv
// Bus bundle of the instruction encoder: control pulses, instruction fields,
// instruction-memory write port and status flags.
interface instr_encoder_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              finish;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        opcode;
    logic [4:0]        rd;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        shamt;
    logic [4:0]        aluop;
    logic [31:0]       imm;
    logic [31:0]       target;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_data;
    logic              imem_ready;
    logic              busy;
    logic              done;
    logic              err_op;
    logic              err_range;
    logic              err_wrap;

    modport master (
        output start, base_addr, finish, in_valid, opcode, rd, rs, rt,
               shamt, aluop, imm, target, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_data, busy, done,
               err_op, err_range, err_wrap
    );

    modport slave (
        input  start, base_addr, finish, in_valid, opcode, rd, rs, rt,
               shamt, aluop, imm, target, imem_ready,
        output in_ready, imem_we, imem_addr, imem_data, busy, done,
               err_op, err_range, err_wrap
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes instruction fields into 32-bit words, buffers them in a small FIFO
// and streams them into instruction memory at consecutive addresses.
module instr_encoder #(
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 12
) (
    input logic           clock,
    input logic           reset,
    instr_encoder_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t            state;
    logic [31:0]       mem [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [PW-1:0]     rd_ptr_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic [ADDR_W-1:0] addr;
    logic              imem_we_q;
    logic [31:0]       imem_data_q;
    logic              done_q;
    logic              err_op_q;
    logic              err_range_q;
    logic              err_wrap_q;

    logic [31:0]       word;
    logic [31:0]       head_next;
    logic              op_bad;
    logic              range_bad;
    logic              in_ready;
    logic              transfer;
    logic              push;
    logic              pop;

    always_comb begin
        word      = '0;
        op_bad    = 1'b0;
        range_bad = 1'b0;
        case (bus.opcode)
            5'b00000:
                word = {bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.aluop, 2'b00};
            5'b00010, 5'b00101, 5'b00110, 5'b00111, 5'b01000: begin
                word      = {bus.opcode, bus.rd, bus.rs, bus.imm[16:0]};
                // In range exactly when the upper bits sign-extend bit 16.
                range_bad = (bus.imm[31:16] != {16{bus.imm[16]}});
            end
            5'b00001, 5'b00011: begin
                word      = {bus.opcode, bus.target[26:0]};
                range_bad = |bus.target[31:27];
            end
            5'b00100:
                word = {bus.opcode, bus.rd, 22'd0};
            default:
                op_bad = 1'b1;
        endcase
    end

    assign in_ready    = (state == RUN) && (count < CW'(FIFO_DEPTH));
    assign transfer    = bus.in_valid & in_ready;
    assign push        = transfer & ~op_bad & ~range_bad;
    assign pop         = imem_we_q & bus.imem_ready;
    assign rd_ptr_next = rd_ptr + PW'(pop);
    assign count_next  = count + CW'(push) - CW'(pop);
    // The output register mirrors the FIFO head; an empty FIFO forwards the new word.
    assign head_next   = (count == CW'(pop)) ? word : mem[rd_ptr_next];

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            addr        <= '0;
            imem_we_q   <= 1'b0;
            imem_data_q <= '0;
            done_q      <= 1'b0;
            err_op_q    <= 1'b0;
            err_range_q <= 1'b0;
            err_wrap_q  <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            rd_ptr      <= rd_ptr_next;
            count       <= count_next;
            imem_we_q   <= (count_next != '0);
            imem_data_q <= (count_next != '0) ? head_next : 32'd0;
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                addr <= addr + ADDR_W'(1);
                if (&addr) begin
                    err_wrap_q <= 1'b1;
                end
            end
            if (transfer && op_bad) begin
                err_op_q <= 1'b1;
            end
            if (transfer && range_bad) begin
                err_range_q <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state       <= RUN;
                        addr        <= bus.base_addr;
                        err_op_q    <= 1'b0;
                        err_range_q <= 1'b0;
                        err_wrap_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (bus.finish) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (count == '0 && !imem_we_q) begin
                        state  <= IDLE;
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.imem_we   = imem_we_q;
    assign bus.imem_addr = addr;
    assign bus.imem_data = imem_data_q;
    assign bus.busy      = (state != IDLE);
    assign bus.done      = done_q;
    assign bus.err_op    = err_op_q;
    assign bus.err_range = err_range_q;
    assign bus.err_wrap  = err_wrap_q;
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// runs, all checked cycle by cycle against a behavioural reference model.
module tb_instr_encoder;
    localparam int ADDR_W     = 12;
    localparam int FIFO_DEPTH = 4;

    typedef enum {M_IDLE, M_RUN, M_DRAIN} mstate_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;
    int   ready_mode = 1;
    bit   mon_en     = 1'b0;

    instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

    instr_encoder #(.FIFO_DEPTH(FIFO_DEPTH), .ADDR_W(ADDR_W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    // Reference model state: words accepted but not yet written, in order.
    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] wr_addr_log[$];
    logic [31:0]       wr_data_log[$];
    mstate_t           m_state     = M_IDLE;
    logic [ADDR_W-1:0] m_addr      = '0;
    bit                m_err_op    = 1'b0;
    bit                m_err_range = 1'b0;
    bit                m_err_wrap  = 1'b0;
    bit                m_done_next = 1'b0;
    bit                m_acc;
    bit                m_bad_op;
    bit                m_bad_range;
    logic [31:0]       m_word;
    int                m_size;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    function automatic void refEncode(input logic [4:0] op, rd, rs, rt, sh, alu,
                                      input logic [31:0] im, tg,
                                      output bit bad_op, output bit bad_range,
                                      output logic [31:0] word);
        longint w  = 0;
        longint iv = longint'($signed(im));
        longint tv = longint'(tg);
        longint ob = longint'(op) * 134217728;
        bad_op    = 1'b0;
        bad_range = 1'b0;
        case (op)
            5'd0: w = ob + longint'(rd) * 4194304 + longint'(rs) * 131072 +
                      longint'(rt) * 4096 + longint'(sh) * 128 + longint'(alu) * 4;
            5'd2, 5'd5, 5'd6, 5'd7, 5'd8: begin
                if (iv < -65536 || iv > 65535) bad_range = 1'b1;
                else w = ob + longint'(rd) * 4194304 + longint'(rs) * 131072 + ((iv + 131072) % 131072);
            end
            5'd1, 5'd3: begin
                if (tv >= 134217728) bad_range = 1'b1;
                else w = ob + tv;
            end
            5'd4: w = ob + longint'(rd) * 4194304;
            default: bad_op = 1'b1;
        endcase
        word = w[31:0];
    endfunction

    always @(negedge clock) begin
        if (mon_en) begin
            m_size = exp_q.size();
            checkOutput("done", 64'(bus.done), 64'(m_done_next));
            m_done_next = 1'b0;
            checkOutput("busy", 64'(bus.busy), 64'(m_state != M_IDLE));
            checkOutput("in_ready", 64'(bus.in_ready), 64'(m_state == M_RUN && m_size < FIFO_DEPTH));
            checkOutput("imem_we", 64'(bus.imem_we), 64'(m_size != 0));
            if (m_size != 0) begin
                checkOutput("imem_addr", 64'(bus.imem_addr), 64'(m_addr));
                checkOutput("imem_data", 64'(bus.imem_data), 64'(exp_q[0]));
            end
            checkOutput("err_op", 64'(bus.err_op), 64'(m_err_op));
            checkOutput("err_range", 64'(bus.err_range), 64'(m_err_range));
            checkOutput("err_wrap", 64'(bus.err_wrap), 64'(m_err_wrap));
            if (reset) begin
                exp_q.delete();
                m_state     = M_IDLE;
                m_addr      = '0;
                m_err_op    = 1'b0;
                m_err_range = 1'b0;
                m_err_wrap  = 1'b0;
                m_done_next = 1'b0;
            end else begin
                if (bus.imem_we && bus.imem_ready) begin
                    wr_addr_log.push_back(bus.imem_addr);
                    wr_data_log.push_back(bus.imem_data);
                end
                m_acc = (m_state == M_RUN) && bus.in_valid && (m_size < FIFO_DEPTH);
                if (m_size != 0 && bus.imem_ready) begin
                    void'(exp_q.pop_front());
                    if (int'(m_addr) == (1 << ADDR_W) - 1) m_err_wrap = 1'b1;
                    m_addr = ADDR_W'((int'(m_addr) + 1) % (1 << ADDR_W));
                end
                if (m_acc) begin
                    refEncode(bus.opcode, bus.rd, bus.rs, bus.rt, bus.shamt, bus.aluop,
                              bus.imm, bus.target, m_bad_op, m_bad_range, m_word);
                    if (m_bad_op) m_err_op = 1'b1;
                    else if (m_bad_range) m_err_range = 1'b1;
                    else exp_q.push_back(m_word);
                end
                case (m_state)
                    M_IDLE: if (bus.start) begin
                        m_state     = M_RUN;
                        m_addr      = bus.base_addr;
                        m_err_op    = 1'b0;
                        m_err_range = 1'b0;
                        m_err_wrap  = 1'b0;
                    end
                    M_RUN: if (bus.finish) m_state = M_DRAIN;
                    default: if (m_size == 0) begin
                        m_state     = M_IDLE;
                        m_done_next = 1'b1;
                    end
                endcase
            end
        end
    end

    // Single driver of imem_ready: 0 = stall, 1 = always ready, 2 = random.
    initial begin
        bus.imem_ready = 1'b1;
        forever begin
            @(posedge clock);
            #2;
            if (ready_mode == 0) bus.imem_ready = 1'b0;
            else if (ready_mode == 1) bus.imem_ready = 1'b1;
            else bus.imem_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic startRun(input logic [ADDR_W-1:0] base);
        bus.start     = 1'b1;
        bus.base_addr = base;
        tick();
        bus.start     = 1'b0;
    endtask

    task automatic applyStimulus(input logic [4:0] op, rd, rs, rt, sh, alu,
                                 input logic [31:0] im, tg, input bit fin);
        int waited = 0;
        bus.opcode = op;  bus.rd = rd;     bus.rs = rs;     bus.rt = rt;
        bus.shamt  = sh;  bus.aluop = alu; bus.imm = im;    bus.target = tg;
        while (bus.in_ready !== 1'b1 && waited < 300) begin
            bus.in_valid = ($urandom_range(0, 1) == 1);
            tick();
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            bus.in_valid = 1'b0;
            checkOutput("accept_timeout", 64'd0, 64'd1);
        end else begin
            bus.in_valid = 1'b1;
            bus.finish   = fin;
            tick();
            bus.in_valid = 1'b0;
            bus.finish   = 1'b0;
        end
    endtask

    task automatic drainAndCheck(input string tag, input bit pulse);
        int pulses = 0;
        int n = 0;
        if (pulse) begin
            bus.finish = 1'b1;
            tick();
            bus.finish = 1'b0;
        end
        while (bus.busy && n < 400) begin
            if (bus.done) pulses++;
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            if (bus.done) pulses++;
            tick();
        end
        checkOutput({tag, "_done_once"}, 64'(pulses), 64'd1);
    endtask

    task automatic clearLog();
        wr_addr_log.delete();
        wr_data_log.delete();
    endtask

    initial begin
        bus.start = 1'b0;  bus.base_addr = '0; bus.finish = 1'b0; bus.in_valid = 1'b0;
        bus.opcode = '0;   bus.rd = '0;        bus.rs = '0;        bus.rt = '0;
        bus.shamt = '0;    bus.aluop = '0;     bus.imm = '0;       bus.target = '0;
        repeat (2) @(posedge clock);
        #1;
        mon_en = 1'b1;
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] addi single write");
        clearLog();
        startRun(12'h010);
        applyStimulus(5'b00101, 5'd1, 5'd2, 5'd0, 5'd0, 5'd0, -32'sd5, 32'd0, 1'b0);
        drainAndCheck("addi", 1'b1);
        checkOutput("addi_count", 64'(wr_data_log.size()), 64'd1);
        if (wr_data_log.size() >= 1) begin
            checkOutput("addi_addr", 64'(wr_addr_log[0]), 64'h010);
            checkOutput("addi_data", 64'(wr_data_log[0]), 64'h2845FFFB);
        end

        $display("[TB] R-type then jump with finish");
        clearLog();
        startRun(12'h100);
        applyStimulus(5'b00000, 5'd3, 5'd4, 5'd5, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(5'b00001, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd100, 1'b1);
        drainAndCheck("rj", 1'b0);
        checkOutput("rj_count", 64'(wr_data_log.size()), 64'd2);
        if (wr_data_log.size() >= 2) begin
            checkOutput("rj_data0", 64'(wr_data_log[0]), 64'h00C85000);
            checkOutput("rj_data1", 64'(wr_data_log[1]), 64'h08000064);
            checkOutput("rj_addr1", 64'(wr_addr_log[1]), 64'h101);
        end

        $display("[TB] range and opcode errors");
        clearLog();
        startRun(12'h020);
        applyStimulus(5'b00101, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 32'd70000, 32'd0, 1'b0);
        applyStimulus(5'b01111, 5'd1, 5'd1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        tick();
        checkOutput("err_range_set", 64'(bus.err_range), 64'd1);
        checkOutput("err_op_set", 64'(bus.err_op), 64'd1);
        checkOutput("err_in_ready", 64'(bus.in_ready), 64'd1);
        checkOutput("err_no_write", 64'(wr_data_log.size()), 64'd0);
        drainAndCheck("err", 1'b1);

        $display("[TB] backpressure with five instructions");
        clearLog();
        startRun(12'h040);
        checkOutput("start_clears_err", 64'({bus.err_op, bus.err_range, bus.err_wrap}), 64'd0);
        ready_mode = 0;
        fork
            for (int i = 0; i < 5; i++)
                applyStimulus(5'b00000, 5'(i + 1), 5'(i + 2), 5'(i + 3), 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
            begin
                repeat (15) tick();
                checkOutput("full_in_ready", 64'(bus.in_ready), 64'd0);
                checkOutput("full_held_data", 64'(bus.imem_data), 64'h00443000);
                ready_mode = 1;
            end
        join
        drainAndCheck("bp", 1'b1);
        checkOutput("bp_count", 64'(wr_data_log.size()), 64'd5);
        if (wr_data_log.size() >= 5) begin
            checkOutput("bp_first", 64'(wr_data_log[0]), 64'h00443000);
            checkOutput("bp_last_addr", 64'(wr_addr_log[4]), 64'h044);
        end

        $display("[TB] address wrap");
        clearLog();
        startRun(12'hFFF);
        applyStimulus(5'b00100, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 1'b0);
        applyStimulus(5'b00011, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd5, 1'b0);
        drainAndCheck("wrap", 1'b1);
        checkOutput("wrap_flag", 64'(bus.err_wrap), 64'd1);
        checkOutput("wrap_count", 64'(wr_data_log.size()), 64'd2);
        if (wr_data_log.size() >= 2) begin
            checkOutput("wrap_addr0", 64'(wr_addr_log[0]), 64'hFFF);
            checkOutput("wrap_addr1", 64'(wr_addr_log[1]), 64'h000);
            checkOutput("wrap_data0", 64'(wr_data_log[0]), 64'h21C00000);
            checkOutput("wrap_data1", 64'(wr_data_log[1]), 64'h18000005);
        end

        $display("[TB] reset with buffered words");
        startRun(12'h080);
        ready_mode = 0;
        for (int i = 0; i < 3; i++)
            applyStimulus(5'b00010, 5'(i), 5'(i), 5'd0, 5'd0, 5'd0, 32'(i * 100), 32'd0, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("rst_imem_we", 64'(bus.imem_we), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy), 64'd0);
        checkOutput("rst_in_ready", 64'(bus.in_ready), 64'd0);
        ready_mode = 1;
        tick();
        clearLog();
        startRun(12'h090);
        applyStimulus(5'b00110, 5'd9, 5'd8, 5'd0, 5'd0, 5'd0, 32'hFFFF0000, 32'd0, 1'b0);
        drainAndCheck("resume", 1'b1);
        checkOutput("resume_count", 64'(wr_data_log.size()), 64'd1);
        if (wr_data_log.size() >= 1) begin
            checkOutput("resume_addr", 64'(wr_addr_log[0]), 64'h090);
            checkOutput("resume_data", 64'(wr_data_log[0]), 64'h32510000);
        end

        $display("[TB] randomized runs");
        ready_mode = 2;
        for (int r = 0; r < 8; r++) begin
            int n_instr = $urandom_range(5, 20);
            bit fin_last = ($urandom_range(0, 1) == 1);
            logic [ADDR_W-1:0] base = ($urandom_range(0, 2) == 0) ? 12'hFFC : ADDR_W'($urandom_range(0, 4095));
            startRun(base);
            for (int k = 0; k < n_instr; k++) begin
                logic [4:0] op;
                logic [31:0] im, tg;
                int sel = $urandom_range(0, 9);
                op = (sel == 9) ? 5'($urandom_range(9, 31)) : 5'(sel);
                im = ($urandom_range(0, 4) != 0) ? 32'(int'($urandom_range(0, 131071)) - 65536) : 32'($urandom);
                tg = ($urandom_range(0, 4) != 0) ? 32'($urandom_range(0, 134217727)) : 32'($urandom);
                applyStimulus(op, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                              im, tg, fin_last && (k == n_instr - 1));
                repeat ($urandom_range(0, 2)) tick();
            end
            drainAndCheck("rand", !fin_last);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 The module SHALL have parameter FIFO_DEPTH, default 4, giving the number of encoded-word buffer entries (power of two, at least 2).
REQ-002 The module SHALL have parameter ADDR_W, default 12, giving the instruction-memory address width.
REQ-003 The module SHALL use one clock; reset is synchronous and active-high.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 start  in  1  one-cycle pulse: load base_addr, enter RUN.
REQ-007 base_addr  in  ADDR_W  first write address.
REQ-008 finish  in  1  one-cycle pulse: stop accepting, drain buffer.
REQ-009 in_valid  in  1  instruction fields valid.
REQ-010 in_ready  out  1  encoder accepts fields this cycle.
REQ-011 opcode  in  5  ISA opcode.
REQ-012 rd, rs, rt, shamt, aluop  in  5 each  register and ALU fields.
REQ-013 imm  in  32  signed immediate.
REQ-014 target  in  32  unsigned jump target.
REQ-015 imem_we  out  1  write strobe, one word per asserted cycle.
REQ-016 imem_addr  out  ADDR_W  write address.
REQ-017 imem_data  out  32  encoded word.
REQ-018 imem_ready  in  1  memory accepts the write this cycle.
REQ-019 busy  out  1  state is RUN or DRAIN.
REQ-020 done  out  1  one-cycle pulse when DRAIN completes.
REQ-021 err_op, err_range, err_wrap  out  1 each  sticky error flags.

Function
REQ-022 Field layout SHALL be: opcode[31:27], rd[26:22], rs[21:17], rt[16:12], shamt[11:7], aluop[6:2], [1:0]=0.
REQ-023 Formats: R = 00000 (all fields); I = 00010, 00101, 00110, 00111, 01000 (rd, rs, imm[16:0] in [16:0]); JI = 00001, 00011 (target[26:0]); JII = 00100 (rd only); unused bits SHALL be 0.
REQ-024 States: IDLE -> RUN on start; RUN -> DRAIN on finish; DRAIN -> IDLE when buffer empty and no write pending, pulsing done in that cycle; start outside IDLE SHALL be ignored.
REQ-025 in_ready SHALL be 1 only in RUN with buffer count < FIFO_DEPTH, with no same-cycle pop bypass.
REQ-026 A transfer (in_valid and in_ready) SHALL encode combinationally and push one word at that edge.
REQ-027 Any other opcode SHALL set err_op, push nothing, and complete the handshake.
REQ-028 An I-format imm outside -65536..65535, or a JI target >= 2^27, SHALL set err_range, push nothing, and complete the handshake.
REQ-029 imem_we/addr/data SHALL be registered; a word pushed at edge N SHALL appear no earlier than cycle N+1 and SHALL hold stable until imem_ready=1.
REQ-030 Each write completed with imem_ready=1 SHALL pop one word and increment the address modulo 2^ADDR_W.
REQ-031 An address wrap from 2^ADDR_W-1 to 0 SHALL set err_wrap, and writing SHALL continue.
REQ-032 A simultaneous push and pop SHALL leave the count unchanged; entries SHALL be written in acceptance order.
REQ-033 finish in the same cycle as a transfer SHALL accept that transfer before entering DRAIN.
REQ-034 start SHALL clear all error flags.

Reset
REQ-035 Reset SHALL clear state to IDLE, empty the buffer, set the address to 0, and drive imem_we, imem_data, in_ready, busy, done, and all err flags to 0.
REQ-036 Reset mid-RUN or mid-DRAIN SHALL discard buffered words, and no write SHALL occur in the cycle after reset.

Verification
REQ-037 start with base_addr=0x010; addi rd=1 rs=2 imm=-5; imem_ready=1 -> one write to 0x010 with data 0x2845FFFB.
REQ-038 R-type rd=3 rs=4 rt=5 shamt=0 aluop=0, then j target=100 -> 0x00C85000 then 0x08000064 at consecutive addresses.
REQ-039 addi imm=70000, then opcode 01111 -> err_range=1 and err_op=1, no imem_we, in_ready stays 1.
REQ-040 imem_ready=0 with 5 valid instructions -> 4 accepted, in_ready=0, imem_data held; imem_ready=1 -> 4 ordered writes, then the 5th is accepted.
REQ-041 base_addr=0xFFF with 2 words -> writes to 0xFFF and 0x000, err_wrap=1; finish -> done pulses once after the last write.
REQ-042 reset asserted with 3 buffered words -> next cycle imem_we=0, busy=0, in_ready=0; a later start resumes cleanly.
